race_min_n: RTL and testbench

- N-input temporal min (first-arrival) operator for the race-logic datapath.
- Pulse-width encoded; a generalised successor to the 2-input min.
- Within each gamma cycle, the earliest-rising input launches exactly one output pulse of PULSE_WIDTH cycles.
- Also reports, per gamma cycle: which input won and the arrival time.
- Gamma-cycle phase is tracked internally, so the block re-arms automatically every GAMMA_CYCLE_WIDTH cycles.

---
 rtl/race_min_n.sv | 146 ++++++++++++++
 tb/tb_race_min_n.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/race_min_n.sv
// N-input temporal min (first arrival) for race logic.
// Optional tie detection: define RACE_MIN_TIE_DETECT_EN.
module race_min_n #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic [N_INPUTS-1:0]                  in_race,
  output logic                                 y,
  output logic                                 gamma_start,
  output logic [$clog2(N_INPUTS)-1:0]          win_idx,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] arr_time,
  output logic                                 out_valid
`ifdef RACE_MIN_TIE_DETECT_EN
  ,
  output logic                                 tie_flag
`endif
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int CW = $clog2(PULSE_WIDTH) + 1;

  localparam logic [TW-1:0] T_LAST  = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] PW_LAST = CW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    FIRING = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] t_q, t_d;
  logic [IW-1:0] win_q, win_d;
  logic [TW-1:0] arr_q, arr_d;
  logic          ov_q, ov_d;
  logic [IW-1:0] win_sel;
  logic          hit;
  logic          bnd;

  assign hit = |in_race;
  assign bnd = (t_q == T_LAST);

  // Lowest-index set input wins a same-cycle tie
  always_comb begin
    win_sel = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (in_race[i]) win_sel = IW'(i);
    end
  end

`ifdef RACE_MIN_TIE_DETECT_EN
  logic tie_q, tie_d;
  logic multi;
  assign multi =
    |(in_race & (in_race - {{(N_INPUTS-1){1'b0}}, 1'b1}));
  assign tie_flag = tie_q;
`endif

  // Phase counter, FSM next state and capture logic
  always_comb begin
    t_d     = bnd ? '0 : t_q + TW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    arr_d   = arr_q;
    ov_d    = ov_q;
`ifdef RACE_MIN_TIE_DETECT_EN
    tie_d   = tie_q;
`endif
    if (bnd) begin
      state_d = ARMED;
      cnt_d   = '0;
      ov_d    = 1'b0;
`ifdef RACE_MIN_TIE_DETECT_EN
      tie_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ARMED: begin
          if (hit) begin
            win_d = win_sel;
            arr_d = t_q;
            ov_d  = 1'b1;
`ifdef RACE_MIN_TIE_DETECT_EN
            tie_d = multi;
`endif
            if (PULSE_WIDTH == 1) begin
              state_d = DONE;
            end else begin
              cnt_d   = CW'(1);
              state_d = FIRING;
            end
          end
        end
        FIRING: begin
          if (cnt_q == PW_LAST) state_d = DONE;
          else                  cnt_d   = cnt_q + CW'(1);
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = ARMED;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (grst) begin
      t_q     <= '0;
      state_q <= ARMED;
      cnt_q   <= '0;
      win_q   <= '0;
      arr_q   <= '0;
      ov_q    <= 1'b0;
`ifdef RACE_MIN_TIE_DETECT_EN
      tie_q   <= 1'b0;
`endif
    end else begin
      t_q     <= t_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      arr_q   <= arr_d;
      ov_q    <= ov_d;
`ifdef RACE_MIN_TIE_DETECT_EN
      tie_q   <= tie_d;
`endif
    end
  end

  assign y = ~grst &
    (((state_q == ARMED) & hit) | (state_q == FIRING));
  assign gamma_start = (t_q == '0);
  assign win_idx     = win_q;
  assign arr_time    = arr_q;
  assign out_valid   = ov_q;

endmodule

// File: tb/tb_race_min_n.sv
// Scoreboard bench for race_min_n: default build plus
// two parameter sweep instances sharing clock and reset.
module tb_race_min_n;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       grst = 1'b1;
  logic [3:0] in_a = '0;
  logic [1:0] in_b = '0;
  logic [7:0] in_c = '0;

  logic ya, gsa, ova;
  logic [1:0] wia;
  logic [3:0] ata;
  logic yb, gsb, ovb;
  logic [0:0] wib;
  logic [1:0] atb;
  logic yc, gsc, ovc;
  logic [2:0] wic;
  logic [4:0] atc;
`ifdef RACE_MIN_TIE_DETECT_EN
  logic tie_a, tie_b, tie_c;
`endif

  race_min_n #(.N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16),
               .PULSE_WIDTH(8)) dut (
    .aclk(aclk), .grst(grst), .in_race(in_a),
    .y(ya), .gamma_start(gsa), .win_idx(wia),
    .arr_time(ata), .out_valid(ova)
`ifdef RACE_MIN_TIE_DETECT_EN
    , .tie_flag(tie_a)
`endif
  );

  race_min_n #(.N_INPUTS(2), .GAMMA_CYCLE_WIDTH(4),
               .PULSE_WIDTH(1)) dut_b (
    .aclk(aclk), .grst(grst), .in_race(in_b),
    .y(yb), .gamma_start(gsb), .win_idx(wib),
    .arr_time(atb), .out_valid(ovb)
`ifdef RACE_MIN_TIE_DETECT_EN
    , .tie_flag(tie_b)
`endif
  );

  race_min_n #(.N_INPUTS(8), .GAMMA_CYCLE_WIDTH(32),
               .PULSE_WIDTH(32)) dut_c (
    .aclk(aclk), .grst(grst), .in_race(in_c),
    .y(yc), .gamma_start(gsc), .win_idx(wic),
    .arr_time(atc), .out_valid(ovc)
`ifdef RACE_MIN_TIE_DETECT_EN
    , .tie_flag(tie_c)
`endif
  );

  typedef struct packed {
    logic       y;
    logic       gs;
    logic       cgs;
    logic       ov;
    logic       cwa;
    logic [2:0] wi;
    logic [4:0] at;
    logic       tie;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int total = 0;
  int bad   = 0;
  int ph[3] = '{0, 0, 0};
  int gl[3] = '{16, 4, 32};

  task automatic chk(string nm, int d, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d",
               nm, d, $time, act, exp);
    end
  endtask

  task automatic cmp(int d, exp_t e, logic y, logic gs,
                     logic ov, int wi, int at);
    chk("y", d, int'(y), int'(e.y));
    if (e.cgs) chk("gamma_start", d, int'(gs), int'(e.gs));
    chk("out_valid", d, int'(ov), int'(e.ov));
    if (e.cwa) begin
      chk("win_idx", d, wi, int'(e.wi));
      chk("arr_time", d, at, int'(e.at));
    end
  endtask

  // Monitor: pop one expectation per DUT per cycle
  always @(negedge aclk) begin : mon
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp(0, e, ya, gsa, ova, int'(wia), int'(ata));
`ifdef RACE_MIN_TIE_DETECT_EN
      chk("tie_flag", 0, int'(tie_a), int'(e.tie));
`endif
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp(1, e, yb, gsb, ovb, int'(wib), int'(atb));
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      cmp(2, e, yc, gsc, ovc, int'(wic), int'(atc));
    end
  end

  function automatic exp_t mk(logic y, logic cgs, logic ov,
                              logic cwa, int wi, int at,
                              logic tie);
    exp_t e;
    e.y   = y;
    e.gs  = 1'b0;
    e.cgs = cgs;
    e.ov  = ov;
    e.cwa = cwa;
    e.wi  = 3'(wi);
    e.at  = 5'(at);
    e.tie = tie;
    return e;
  endfunction

  // One clock: drive target DUT d (3 = none), queue expectation
  task automatic step(int d, logic r, logic [7:0] in, exp_t e);
    @(posedge aclk);
    #1;
    grst = r;
    in_a = (d == 0) ? in[3:0] : 4'h0;
    in_b = (d == 1) ? in[1:0] : 2'h0;
    in_c = (d == 2) ? in : 8'h00;
    if (d < 3) begin
      e.gs = (ph[d] == 0);
      if (d == 0) qa.push_back(e);
      if (d == 1) qb.push_back(e);
      if (d == 2) qc.push_back(e);
    end
    for (int k = 0; k < 3; k++)
      ph[k] = r ? 0 : (ph[k] + 1) % gl[k];
  endtask

  task automatic align(int d);
    while (ph[d] != 0) step(3, 1'b0, 8'h00, '0);
  endtask

  // One gamma cycle: input in0, switching to in1 at p1 and in2
  // at p2; y expected high for ylo..yhi, out_valid from ovlo.
  task automatic gcycle(int d, logic [7:0] in0, int p1,
                        logic [7:0] in1, int p2,
                        logic [7:0] in2, int ylo, int yhi,
                        int ovlo, int wi, int at, logic tie,
                        logic chkall);
    logic [7:0] v;
    logic ey, eov;
    align(d);
    for (int t = 0; t < gl[d]; t++) begin
      v   = (t < p1) ? in0 : ((t < p2) ? in1 : in2);
      ey  = (ylo >= 0) && (t >= ylo) && (t <= yhi);
      eov = (t >= ovlo);
      step(d, 1'b0, v,
           mk(ey, 1'b1, eov, eov | chkall, wi, at,
              eov ? tie : 1'b0));
    end
  endtask

  initial begin
    // Reset held two cycles
    step(0, 1'b1, 8'h00, mk(0, 0, 0, 1, 0, 0, 0));
    step(0, 1'b1, 8'h00, mk(0, 0, 0, 1, 0, 0, 0));
    // Idle: gamma_start at 0, 16, 32
    for (int g = 0; g < 3; g++)
      gcycle(0, 8'h00, 99, 8'h00, 99, 8'h00,
             -1, 0, 99, 0, 0, 0, 1);
    // Single arrival of input 2 at t=3, held high
    gcycle(0, 8'h00, 3, 8'h04, 99, 8'h04,
           3, 10, 4, 2, 3, 0, 0);
    gcycle(0, 8'h04, 99, 8'h04, 99, 8'h04,
           0, 7, 1, 2, 0, 0, 0);
    // Tie of inputs 3 and 1 at t=5, input 0 later at t=7
    gcycle(0, 8'h00, 5, 8'h0A, 7, 8'h0B,
           5, 12, 6, 1, 5, 1, 0);
    // Truncation at the gamma boundary
    gcycle(0, 8'h00, 12, 8'h01, 99, 8'h01,
           12, 15, 13, 0, 12, 0, 0);
    // Arrival only in the last phase: 1-cycle y, no capture
    gcycle(0, 8'h00, 15, 8'h01, 99, 8'h01,
           15, 15, 99, 0, 0, 0, 0);
    gcycle(0, 8'h00, 99, 8'h00, 99, 8'h00,
           -1, 0, 99, 0, 0, 0, 0);
    // Reset in pulse cycle 4 of 8 (arrival at t=2)
    align(0);
    for (int t = 0; t < 5; t++)
      step(0, 1'b0, (t >= 2) ? 8'h04 : 8'h00,
           mk(t >= 2, 1, t >= 3, t >= 3, 2, 2, 0));
    step(0, 1'b1, 8'h04, mk(0, 0, 1, 1, 2, 2, 0));
    step(0, 1'b0, 8'h04, mk(1, 1, 0, 1, 0, 0, 0));
    gcycle(0, 8'h04, 99, 8'h04, 99, 8'h04,
           0, 7, 1, 2, 0, 0, 0);
    // N=2, G=4, PW=1
    gcycle(1, 8'h00, 1, 8'h02, 2, 8'h03,
           1, 1, 2, 1, 1, 0, 0);
    gcycle(1, 8'h03, 99, 8'h03, 99, 8'h03,
           0, 0, 1, 0, 0, 0, 0);
    gcycle(1, 8'h00, 3, 8'h01, 99, 8'h01,
           3, 3, 99, 0, 0, 0, 0);
    // N=8, G=32, PW=32
    gcycle(2, 8'h80, 99, 8'h80, 99, 8'h80,
           0, 31, 1, 7, 0, 0, 0);
    gcycle(2, 8'h00, 10, 8'h30, 20, 8'h31,
           10, 31, 11, 4, 10, 0, 0);
    gcycle(2, 8'h00, 99, 8'h00, 99, 8'h00,
           -1, 0, 99, 0, 0, 0, 0);
    @(negedge aclk);
    #1;
    total++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0",
               qa.size() + qb.size() + qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
